// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the FIFO: memory read port plus the valid/ready output handshake.
// The controller side uses the master modport; memory and consumer use slave.
interface fifo_rd_ctrl_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic [ADDRSIZE-1:0] raddr;
  logic [DATASIZE-1:0] rdata;
  logic [DATASIZE-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;

  modport master (
    output raddr,
    input  rdata,
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  raddr,
    output rdata,
    input  dout,
    input  dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: read pointer, empty flag and a registered valid/ready output stage.
// Optional FIFO_RD_LEVEL_EN adds the rlevel word count and the raempty almost-empty flag.
module fifo_rd_ctrl #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
`ifdef FIFO_RD_LEVEL_EN
  ,
  parameter int AEMPTY_THRESH = 2
`endif
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
`ifdef FIFO_RD_LEVEL_EN
  output logic [ADDRSIZE:0]   rlevel,
  output logic                raempty,
`endif
  fifo_rd_ctrl_if.master      bus
);

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;

  out_state_t          state;
  out_state_t          state_next;
  logic [ADDRSIZE:0]   rbin;
  logic [ADDRSIZE:0]   rbinnext;
  logic [ADDRSIZE:0]   rgraynext;
  logic [DATASIZE-1:0] dout_reg;
  logic                valid;
  logic                rinc;

  assign valid          = (state == OUT_FULL);
  assign bus.dout_valid = valid;
  assign bus.dout       = dout_reg;
  assign bus.raddr      = rbin[ADDRSIZE-1:0];

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // A read happens only when the output stage is free or being drained this cycle.
  always_comb begin
    state_next = state;
    rinc       = !rempty && (!valid || bus.dout_ready);
    rbinnext   = rbin + {{ADDRSIZE{1'b0}}, rinc};
    rgraynext  = (rbinnext >> 1) ^ rbinnext;
    case (state)
      OUT_EMPTY: if (rinc) state_next = OUT_FULL;
      OUT_FULL:  if (bus.dout_ready && !rinc) state_next = OUT_EMPTY;
      default:   state_next = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin     <= '0;
      rptr     <= '0;
      rempty   <= 1'b1;
      dout_reg <= '0;
    end else begin
      rbin   <= rbinnext;
      rptr   <= rgraynext;
      rempty <= (rgraynext == rq2_wptr);
      if (rinc) begin
        dout_reg <= bus.rdata;
      end
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] level_next;

  // The word parked in dout has already left memory, so it is not counted.
  always_comb begin
    wbin[ADDRSIZE] = rq2_wptr[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ rq2_wptr[i];
    end
    level_next = wbin - rbinnext;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rlevel  <= '0;
      raempty <= 1'b1;
    end else begin
      rlevel  <= level_next;
      raempty <= (level_next <= (ADDRSIZE+1)'(AEMPTY_THRESH));
    end
  end
`endif

endmodule
